wt_mem_arbiter: RTL and testbench

WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

---
 rtl/wt_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_wt_mem_arbiter.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter that merges icache and dcache requests onto one memory port.
// One downstream request at a time; per-port outstanding counters throttle grants.
module wt_mem_arbiter #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  input  logic                 icache_req_i,
  input  logic [AddrWidth-1:0] icache_addr_i,
  output logic                 icache_ack_o,
  input  logic                 dcache_req_i,
  input  logic [AddrWidth-1:0] dcache_addr_i,
  input  logic                 dcache_we_i,
  input  logic [DataWidth-1:0] dcache_wdata_i,
  output logic                 dcache_ack_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 mem_port_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rtrn_vld_i,
  input  logic                 mem_rtrn_port_i,
  input  logic [DataWidth-1:0] mem_rtrn_data_i,
  output logic                 icache_rtrn_vld_o,
  output logic                 dcache_rtrn_vld_o,
  output logic [DataWidth-1:0] rtrn_data_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax =
    CntWidth'(MaxOutstanding);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   gnt_port_q;
  logic   grant;
  logic   sel;
  logic [1:0] elig;
  logic [1:0] ack;
  logic [1:0] rtrn;
  logic [1:0][CntWidth-1:0] cnt_q;

  assign elig[0] = icache_req_i && (cnt_q[0] < CntMax);
  assign elig[1] = dcache_req_i && (cnt_q[1] < CntMax);

  assign rtrn[0] = mem_rtrn_vld_i && !mem_rtrn_port_i;
  assign rtrn[1] = mem_rtrn_vld_i && mem_rtrn_port_i;

  assign icache_rtrn_vld_o = rtrn[0];
  assign dcache_rtrn_vld_o = rtrn[1];
  assign rtrn_data_o       = mem_rtrn_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Priority only rotates when both ports actually compete.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant   = 1'b0;
    sel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stall_i && (|elig)) begin
          grant   = 1'b1;
          state_d = GRANT;
          if (&elig) begin
            sel    = prio_q;
            prio_d = ~prio_q;
          end else begin
            sel = elig[1];
          end
        end
      end
      GRANT: begin
        if (mem_ack_i) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req_o = 1'b0;
    ack       = '0;
    if (state_q == GRANT) begin
      mem_req_o       = 1'b1;
      ack[gnt_port_q] = mem_ack_i;
    end
  end

  assign icache_ack_o = ack[0];
  assign dcache_ack_o = ack[1];
  assign mem_port_o   = gnt_port_q;
  assign busy_o       = (state_q == GRANT) || (|cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_port_q  <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
    end else if (grant) begin
      gnt_port_q  <= sel;
      mem_addr_o  <= sel ? dcache_addr_i : icache_addr_i;
      mem_we_o    <= sel & dcache_we_i;
      mem_wdata_o <= sel ? dcache_wdata_i : '0;
    end
  end

  // Ack and return together cancel; a stray return never underflows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ack[p] && !rtrn[p]) begin
          cnt_q[p] <= cnt_q[p] + 1'b1;
        end else if (rtrn[p] && !ack[p] && cnt_q[p] != '0) begin
          cnt_q[p] <= cnt_q[p] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Bench for wt_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_wt_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ireq, dreq, dwe;
  logic [63:0] iaddr, daddr, dwdata;
  logic        iack, dack;
  logic        mreq, mwe, mport;
  logic [63:0] maddr, mwdata;
  logic        mem_ack;
  logic        rvld, rport;
  logic [63:0] rdata, rtdata;
  logic        irv, drv, busy;

  int checks;
  int failures;

  wt_mem_arbiter #(
    .AddrWidth(64),
    .DataWidth(64),
    .MaxOutstanding(4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .stall_i          (stall),
    .icache_req_i     (ireq),
    .icache_addr_i    (iaddr),
    .icache_ack_o     (iack),
    .dcache_req_i     (dreq),
    .dcache_addr_i    (daddr),
    .dcache_we_i      (dwe),
    .dcache_wdata_i   (dwdata),
    .dcache_ack_o     (dack),
    .mem_req_o        (mreq),
    .mem_addr_o       (maddr),
    .mem_we_o         (mwe),
    .mem_wdata_o      (mwdata),
    .mem_port_o       (mport),
    .mem_ack_i        (mem_ack),
    .mem_rtrn_vld_i   (rvld),
    .mem_rtrn_port_i  (rport),
    .mem_rtrn_data_i  (rdata),
    .icache_rtrn_vld_o(irv),
    .dcache_rtrn_vld_o(drv),
    .rtrn_data_o      (rtdata),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    stall   = 1'b0;
    ireq    = 1'b0;
    dreq    = 1'b0;
    dwe     = 1'b0;
    iaddr   = '0;
    daddr   = '0;
    dwdata  = '0;
    mem_ack = 1'b0;
    rvld    = 1'b0;
    rport   = 1'b0;
    rdata   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    ireq    = 1'b1;
    dreq    = 1'b1;
    dwe     = 1'b1;
    mem_ack = 1'b1;
    iaddr   = '1;
    daddr   = '1;
    dwdata  = '1;
    #1;
    checks++;
    if ({mreq, iack, dack, busy, mwe, mport} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {mreq, iack, dack, busy, mwe, mport});
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mreq, iack, dack, busy, mwe, mport} !== 6'b0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=000000",
               {mreq, iack, dack, busy, mwe, mport});
    end
    checks++;
    if (maddr !== 64'h0 || mwdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h exp=0",
               maddr, mwdata);
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_priority();
    apply_reset();
    iaddr = 64'h1000;
    daddr = 64'h2000;
    ireq  = 1'b1;
    dreq  = 1'b1;
    #1;
    checks++;
    if (mreq !== 1'b0) begin
      failures++;
      $display("FAIL prio_grant_cycle mreq=%b exp=0", mreq);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mreq, mport, mwe, iack} !== 4'b1000 ||
        maddr !== 64'h1000) begin
      failures++;
      $display("FAIL prio_first got=%b addr=%h exp=1000 addr=1000",
               {mreq, mport, mwe, iack}, maddr);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    checks++;
    if ({iack, dack, mport} !== 3'b100) begin
      failures++;
      $display("FAIL prio_iack got=%b exp=100", {iack, dack, mport});
    end
    @(negedge clk);
    ireq    = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mreq !== 1'b0) begin
      failures++;
      $display("FAIL prio_gap mreq=%b exp=0", mreq);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mreq, mport} !== 2'b11 || maddr !== 64'h2000) begin
      failures++;
      $display("FAIL prio_second got=%b addr=%h exp=11 addr=2000",
               {mreq, mport}, maddr);
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if ({iack, dack} !== 2'b01) begin
      failures++;
      $display("FAIL prio_dack got=%b exp=01", {iack, dack});
    end
    @(negedge clk);
    dreq    = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({mreq, busy} !== 2'b01) begin
      failures++;
      $display("FAIL prio_after got=%b exp=01", {mreq, busy});
    end
  endtask

  task automatic test_write_hold();
    apply_reset();
    dreq   = 1'b1;
    dwe    = 1'b1;
    daddr  = 64'h8000_1000;
    dwdata = 64'hDEAD_BEEF;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({mreq, mwe, mport, dack, iack} !== 5'b11100 ||
          maddr !== 64'h8000_1000 || mwdata !== 64'hDEAD_BEEF) begin
        failures++;
        $display("FAIL write_hold[%0d] got=%b a=%h d=%h exp=11100",
                 i, {mreq, mwe, mport, dack, iack}, maddr, mwdata);
      end
      daddr  = {$urandom, $urandom};
      dwdata = {$urandom, $urandom};
      dwe    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if ({dack, iack, mwe} !== 3'b101 || maddr !== 64'h8000_1000) begin
      failures++;
      $display("FAIL write_ack got=%b a=%h exp=101",
               {dack, iack, mwe}, maddr);
    end
    @(negedge clk);
    dreq    = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({dack, mreq} !== 2'b00) begin
      failures++;
      $display("FAIL write_single got=%b exp=00", {dack, mreq});
    end
  endtask

  task automatic test_max_outstanding();
    apply_reset();
    ireq  = 1'b1;
    iaddr = 64'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      checks++;
      if ({mreq, iack} !== 2'b11) begin
        failures++;
        $display("FAIL maxout_fill[%0d] got=%b exp=11", i, {mreq, iack});
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if ({mreq, busy} !== 2'b01) begin
        failures++;
        $display("FAIL maxout_block[%0d] got=%b exp=01", j, {mreq, busy});
      end
      @(negedge clk);
    end
    rvld  = 1'b1;
    rport = 1'b0;
    rdata = {$urandom, $urandom};
    #1;
    checks++;
    if ({irv, drv} !== 2'b10 || rtdata !== rdata) begin
      failures++;
      $display("FAIL maxout_rtrn got=%b d=%h exp=10 d=%h",
               {irv, drv}, rtdata, rdata);
    end
    @(negedge clk);
    rvld = 1'b0;
    #1;
    checks++;
    if (mreq !== 1'b0) begin
      failures++;
      $display("FAIL maxout_rtrn_cycle mreq=%b exp=0", mreq);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mreq, mport} !== 2'b10) begin
      failures++;
      $display("FAIL maxout_fifth got=%b exp=10", {mreq, mport});
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    ireq    = 1'b0;
  endtask

  task automatic test_ack_rtrn_same();
    apply_reset();
    dreq  = 1'b1;
    daddr = 64'h300;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    @(negedge clk);
    mem_ack = 1'b1;
    rvld    = 1'b1;
    rport   = 1'b1;
    #1;
    checks++;
    if ({dack, drv, irv} !== 3'b110) begin
      failures++;
      $display("FAIL same_cycle got=%b exp=110", {dack, drv, irv});
    end
    @(negedge clk);
    mem_ack = 1'b0;
    rvld    = 1'b0;
    dreq    = 1'b0;
    #1;
    checks++;
    if ({mreq, busy} !== 2'b01) begin
      failures++;
      $display("FAIL same_busy got=%b exp=01", {mreq, busy});
    end
    rvld = 1'b1;
    @(negedge clk);
    rvld = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL same_cnt_one busy=%b exp=1", busy);
    end
    rvld = 1'b1;
    @(negedge clk);
    rvld = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL same_cnt_zero busy=%b exp=0", busy);
    end
    rvld = 1'b1;
    @(negedge clk);
    rvld = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL underflow busy=%b exp=0", busy);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    stall = 1'b1;
    ireq  = 1'b1;
    dreq  = 1'b1;
    iaddr = 64'hA0;
    daddr = 64'hB0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({mreq, busy} !== 2'b00) begin
        failures++;
        $display("FAIL stall_block[%0d] got=%b exp=00", j, {mreq, busy});
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (mreq !== 1'b0) begin
      failures++;
      $display("FAIL stall_drop mreq=%b exp=0", mreq);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mreq, mport} !== 2'b10 || maddr !== 64'hA0) begin
      failures++;
      $display("FAIL stall_grant got=%b a=%h exp=10 a=a0",
               {mreq, mport}, maddr);
    end
    stall = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (mreq !== 1'b1) begin
      failures++;
      $display("FAIL stall_issued mreq=%b exp=1", mreq);
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (iack !== 1'b1) begin
      failures++;
      $display("FAIL stall_ack iack=%b exp=1", iack);
    end
    @(negedge clk);
    ireq    = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mreq !== 1'b0) begin
      failures++;
      $display("FAIL stall_rehold mreq=%b exp=0", mreq);
    end
    stall = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mreq, mport} !== 2'b11) begin
      failures++;
      $display("FAIL stall_dgrant got=%b exp=11", {mreq, mport});
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    dreq    = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    ireq  = 1'b1;
    iaddr = 64'h77;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mreq, busy} !== 2'b11) begin
      failures++;
      $display("FAIL midrst_pre got=%b exp=11", {mreq, busy});
    end
    mem_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mreq, iack, dack, busy} !== 4'b0 || maddr !== 64'h0) begin
      failures++;
      $display("FAIL midrst_async got=%b a=%h exp=0000",
               {mreq, iack, dack, busy}, maddr);
    end
    @(negedge clk);
    ireq    = 1'b0;
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({mreq, busy} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_after got=%b exp=00", {mreq, busy});
    end
  endtask

  task automatic test_random();
    bit          infl, mp, mwe_m, prio, iact, dact;
    bit          ea, eb, ei, ed, e_busy, r0, r1;
    logic [63:0] ma, mw;
    int          cnt[2];
    logic [5:0]  exp_ctrl;
    apply_reset();
    infl = 0; mp = 0; mwe_m = 0; prio = 0;
    iact = 0; dact = 0; ma = '0; mw = '0;
    cnt[0] = 0; cnt[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!iact && $urandom_range(0, 1) == 1) begin
        iact  = 1;
        iaddr = {$urandom, $urandom};
      end
      if (!dact && $urandom_range(0, 1) == 1) begin
        dact   = 1;
        daddr  = {$urandom, $urandom};
        dwe    = 1'($urandom_range(0, 1));
        dwdata = {$urandom, $urandom};
      end
      ireq    = iact;
      dreq    = dact;
      stall   = ($urandom_range(0, 4) == 0);
      mem_ack = ($urandom_range(0, 2) != 0);
      rvld    = ($urandom_range(0, 3) == 0);
      rport   = 1'($urandom_range(0, 1));
      rdata   = {$urandom, $urandom};
      #1;
      ei     = infl && mem_ack && !mp;
      ed     = infl && mem_ack && mp;
      r0     = rvld && !rport;
      r1     = rvld && rport;
      e_busy = infl || cnt[0] != 0 || cnt[1] != 0;
      exp_ctrl = {infl, ei, ed, r0, r1, e_busy};
      checks++;
      if ({mreq, iack, dack, irv, drv, busy} !== exp_ctrl ||
          rtdata !== rdata) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b",
                 cyc, {mreq, iack, dack, irv, drv, busy}, exp_ctrl);
      end
      if (infl) begin
        checks++;
        if (maddr !== ma || mwe !== mwe_m || mport !== mp ||
            (mp && mwdata !== mw)) begin
          failures++;
          $display("FAIL rand_req cyc=%0d a=%h we=%b p=%b exp a=%h we=%b p=%b",
                   cyc, maddr, mwe, mport, ma, mwe_m, mp);
        end
      end
      if (infl) begin
        if (mem_ack) infl = 0;
      end else if (!stall) begin
        ea = ireq && cnt[0] < 4;
        eb = dreq && cnt[1] < 4;
        if (ea || eb) begin
          if (ea && eb) begin
            mp   = prio;
            prio = !prio;
          end else begin
            mp = eb;
          end
          infl  = 1;
          ma    = mp ? daddr : iaddr;
          mwe_m = mp ? dwe : 1'b0;
          mw    = dwdata;
        end
      end
      if (ei && !r0) cnt[0]++;
      else if (r0 && !ei && cnt[0] > 0) cnt[0]--;
      if (ed && !r1) cnt[1]++;
      else if (r1 && !ed && cnt[1] > 0) cnt[1]--;
      if (ei) iact = 0;
      if (ed) dact = 0;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_priority();
    test_write_hold();
    test_max_outstanding();
    test_ack_rtrn_same();
    test_stall();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
